// File: rtl/p251_rej_sampler.sv
// ---------------------------------------------------------------------------
// p251_rej_sampler
//
// Purpose:
//   Rejection sampler for GF(251). The block consumes random words (XOF
//   output) byte by byte, from byte 0 = bits [7:0] upward. Bytes below 251
//   are emitted unchanged as field elements. Bytes 251..255 are dropped.
//   A run ends after N_OUT elements have been emitted. Any bytes left in the
//   current word at that point are discarded, so the next run always starts
//   on a fresh word.
//
// Parameters:
//   IN_W   input word width; a multiple of 8 and at least 8 (BPW = IN_W/8)
//   N_OUT  elements emitted per run (>= 1)
//
// Ports:
//   i_clk        clock; all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      start one run; only honoured in IDLE
//   i_in         random input word
//   i_in_valid   i_in carries a word
//   o_in_ready   a word is accepted this cycle (LOAD state only)
//   o_out        sampled element, 0..250
//   o_out_valid  o_out holds an accepted element
//   i_out_ready  downstream takes o_out this cycle
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse after the last element of a run
//   o_rej_cnt    (P251_REJ_STATS_EN only) bytes rejected in the current run,
//                saturating at 16'hFFFF
//   o_dbg_state  current FSM state (0 IDLE, 1 LOAD, 2 SCAN, 3 DONE)
//
// Handshake:
//   Both sides use valid/ready. A word or element transfers only on a rising
//   edge where valid and ready are both high. While valid is high and ready
//   is low, the producer holds its data and valid stable.
//
// Optional feature macro: P251_REJ_STATS_EN (adds o_rej_cnt).
// ---------------------------------------------------------------------------
module p251_rej_sampler #(
    parameter int IN_W  = 32,
    parameter int N_OUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [IN_W-1:0] i_in,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    output logic [7:0]      o_out,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic            o_busy,
    output logic            o_done,
`ifdef P251_REJ_STATS_EN
    output logic [15:0]     o_rej_cnt,
`endif
    output logic [1:0]      o_dbg_state
);

    localparam int BPW   = IN_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CNT_W = $clog2(N_OUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [7:0]        cur_byte;
    logic              accept;
    logic              last_byte;
    logic              advance;

    // Byte under inspection. The shift keeps the select legal for any BPW.
    assign cur_byte  = 8'(word_q >> {idx_q, 3'b000});
    assign accept    = (cur_byte < 8'd251);
    assign last_byte = (idx_q == IDX_W'(BPW - 1));
    // Rejected bytes advance unconditionally. Accepted bytes advance only
    // when they transfer downstream.
    assign advance   = !accept || i_out_ready;

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_in_valid) begin
                    word_d  = i_in;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (advance) begin
                    if (accept) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    idx_d = last_byte ? '0 : idx_q + IDX_W'(1);
                    // The final element ends the run at once. Any bytes
                    // still unread in the word are dropped.
                    if (accept && (cnt_q == CNT_W'(N_OUT - 1))) begin
                        state_d = S_DONE;
                    end else if (last_byte) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs (decoded from the registered state)
    // -----------------------------------------------------------------------
    always_comb begin
        o_in_ready  = (state_q == S_LOAD);
        o_out_valid = (state_q == S_SCAN) && accept;
        o_out       = (state_q == S_SCAN) ? cur_byte : 8'd0;
        o_busy      = (state_q != S_IDLE);
        o_done      = (state_q == S_DONE);
        o_dbg_state = state_q;
    end

`ifdef P251_REJ_STATS_EN
    // -----------------------------------------------------------------------
    // Rejected-byte statistics for the current run
    // -----------------------------------------------------------------------
    logic [15:0] rej_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rej_q <= '0;
        end else if ((state_q == S_IDLE) && i_start) begin
            rej_q <= '0;
        end else if ((state_q == S_SCAN) && !accept && (rej_q != 16'hFFFF)) begin
            rej_q <= rej_q + 16'd1;
        end
    end

    assign o_rej_cnt = rej_q;
`endif

endmodule

// File: tb/tb_p251_rej_sampler.sv
module tb_p251_rej_sampler;

  localparam int IN_W  = 32;
  localparam int N_OUT = 4;
  localparam int BPW   = IN_W / 8;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start;
  logic [IN_W-1:0] i_in;
  logic            i_in_valid;
  logic            o_in_ready;
  logic [7:0]      o_out;
  logic            o_out_valid;
  logic            i_out_ready;
  logic            o_busy;
  logic            o_done;
  logic [1:0]      o_dbg_state;
`ifdef P251_REJ_STATS_EN
  logic [15:0]     o_rej_cnt;
`endif

  always #5 clk = ~clk;

  p251_rej_sampler #(.IN_W(IN_W), .N_OUT(N_OUT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_in        (i_in),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_out       (o_out),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
`ifdef P251_REJ_STATS_EN
    .o_rej_cnt   (o_rej_cnt),
`endif
    .o_dbg_state (o_dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] src_q[$];
  int          words_taken = 0;
  int          done_seen = 0;
  int          in_valid_pct = 100;
  bit          ready_rand = 1'b0;
  logic        ready_val = 1'b1;
  bit          stalled = 1'b0;
  logic [7:0]  stall_val = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: walk the byte stream, keep bytes < 251 until N_OUT are
  // collected; report words consumed and bytes rejected along the way.
  // -------------------------------------------------------------------------
  task automatic model_run(input logic [31:0] words[$], output int n_words, output int n_rej);
    int got = 0;
    n_words = 0;
    n_rej   = 0;
    foreach (words[w]) begin
      logic [31:0] cw;
      if (got == N_OUT) break;
      cw = words[w];
      n_words++;
      for (int b = 0; b < BPW; b++) begin
        logic [7:0] v;
        if (got == N_OUT) break;
        v = cw[8*b +: 8];
        if (v < 8'd251) begin
          exp_q.push_back(v);
          got++;
        end else begin
          n_rej++;
        end
      end
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    for (int b = 0; b < BPW; b++) begin
      if ($urandom_range(0, 9) < 3) w[8*b +: 8] = 8'($urandom_range(251, 255));
      else                          w[8*b +: 8] = 8'($urandom_range(0, 250));
    end
    return w;
  endfunction

  // -------------------------------------------------------------------------
  // Drivers: word source and downstream ready
  // -------------------------------------------------------------------------
  initial begin
    bit tk;
    i_in_valid = 1'b0;
    i_in = '0;
    forever begin
      @(negedge clk);
      tk = i_in_valid && o_in_ready && rst_n;
      @(posedge clk);
      #1;
      if (tk && src_q.size() > 0) begin
        void'(src_q.pop_front());
        words_taken++;
      end
      if (src_q.size() > 0 && $urandom_range(0, 99) < in_valid_pct) begin
        i_in_valid = 1'b1;
        i_in = src_q[0];
      end else begin
        i_in_valid = 1'b0;
        i_in = $urandom;
      end
    end
  end

  initial begin
    i_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: pops the expected queue on every output transfer, checks that a
  // stalled element is held, and counts done pulses.
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled) begin
        chk("hold_valid", 32'(o_out_valid), 32'd1);
        chk("hold_value", 32'(o_out), 32'(stall_val));
      end
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'(o_out), 32'hFFFF_FFFF);
        else                   chk("out_value", 32'(o_out), 32'(exp_q.pop_front()));
      end
      stalled   = o_out_valid && !i_out_ready;
      stall_val = o_out;
      if (o_done) done_seen++;
    end else begin
      stalled = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Run helpers
  // -------------------------------------------------------------------------
  int run_words;
  int run_rej;
  int run_taken0;
  int run_done0;
  int run_srcn;

  task automatic start_run(input logic [31:0] words[$]);
    exp_q.delete();
    src_q = words;
    run_srcn = words.size();
    model_run(words, run_words, run_rej);
    run_taken0 = words_taken;
    run_done0  = done_seen;
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input bit start_noise, output int cycles);
    cycles = 0;
    if (start_noise) i_start = 1'b1;
    do begin
      @(negedge clk);
      cycles++;
    end while (!o_done && cycles < 2000);
    chk({tag, "_done_pulse"}, 32'(o_done), 32'd1);
    @(posedge clk);
    #1 i_start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
    chk({tag, "_idle_after"}, 32'(o_busy), 32'd0);
    chk({tag, "_done_count"}, 32'(done_seen - run_done0), 32'd1);
    chk({tag, "_words_used"}, 32'(words_taken - run_taken0), 32'(run_words));
    chk({tag, "_words_left"}, 32'(src_q.size()), 32'(run_srcn - run_words));
    chk({tag, "_exp_drained"}, 32'(exp_q.size()), 32'd0);
`ifdef P251_REJ_STATS_EN
    chk({tag, "_rej_cnt"}, 32'(o_rej_cnt), 32'(run_rej));
`endif
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] w[$];
    int cyc;
    int acc;
    int guard;

    rst_n = 1'b0;
    i_start = 1'b0;
    #3;
    chk("rst_out", 32'(o_out), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // In-order outputs on consecutive cycles, done one cycle later.
    w = '{32'h0302_0100, 32'h0706_0504};
    start_run(w);
    finish_run("consec", 1'b0, cyc);
    chk("consec_latency", 32'(cyc), 32'd6);

    // Mixed rejects across two words.
    w = '{32'hFB01_FAFF, 32'h0A0B_0CFC};
    start_run(w);
    finish_run("mixed", 1'b0, cyc);

    // Two fully/partly rejected words before the final element.
    w = '{32'hFFFF_FFFF, 32'h0000_00FB, 32'h0000_0005, 32'h1111_1111};
    start_run(w);
    finish_run("rejrun", 1'b0, cyc);

    // Held element while downstream stalls; i_start held high is ignored.
    ready_val = 1'b0;
    w = '{32'h0102_0307};
    start_run(w);
    guard = 0;
    while (!o_out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("stall_first_valid", 32'(o_out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_out", 32'(o_out), 32'd7);
      chk("stall_valid", 32'(o_out_valid), 32'd1);
    end
    ready_val = 1'b1;
    finish_run("stall", 1'b1, cyc);

    // Reset in the middle of a scan.
    ready_rand = 1'b1;
    w = '{32'h0102_0304, 32'h0506_0708};
    start_run(w);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(o_out_valid && i_out_ready) && guard < 200);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(o_out), 32'd0);
    chk("midrst_out_valid", 32'(o_out_valid), 32'd0);
    chk("midrst_in_ready", 32'(o_in_ready), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_done", 32'(o_done), 32'd0);
`ifdef P251_REJ_STATS_EN
    chk("midrst_rej", 32'(o_rej_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2;
    src_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 32'(done_seen - run_done0), 32'd0);
    chk("midrst_idle", 32'(o_busy), 32'd0);

    // Randomized runs with source and sink back-pressure.
    in_valid_pct = 70;
    for (int r = 0; r < 40; r++) begin
      w.delete();
      acc = 0;
      while (acc < N_OUT) begin
        logic [31:0] nw;
        nw = rnd_word();
        w.push_back(nw);
        for (int b = 0; b < BPW; b++) if (nw[8*b +: 8] < 8'd251) acc++;
      end
      if ($urandom_range(0, 1) == 1) w.push_back(rnd_word());
      start_run(w);
      finish_run("rand", 1'($urandom_range(0, 1)), cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
